tmds_encoder: RTL and testbench

TMDS_ENCODER -- requirements
Module: tmds_encoder

---
 rtl/tmds_encoder.sv | 98 +++++++++
 tb/tb_tmds_encoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder.sv
// DVI/HDMI TMDS 8b/10b encoder: transition-minimising stage, then DC-balancing stage.
// Two register stages, one symbol per pixclk, no backpressure.
module tmds_encoder (
  input  logic       pixclk,
  input  logic       rst_n,
  input  logic       vde,
  input  logic [7:0] data,
  input  logic       c0,
  input  logic       c1,
  output logic [9:0] tmds
);

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  logic [3:0]        n1_data;
  logic              use_xnor;
  logic [8:0]        qm_next;

  logic [8:0]        qm;
  logic [3:0]        qm_ones;
  logic              vde_d;
  logic              c0_d;
  logic              c1_d;

  logic signed [4:0] cnt;
  logic signed [4:0] cnt_next;
  logic signed [4:0] diff;
  logic [9:0]        sym_next;

  always_comb begin
    n1_data  = ones8(data);
    use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data[0]);
    qm_next  = '0;
    qm_next[0] = data[0];
    for (int i = 1; i < 8; i++) begin
      qm_next[i] = use_xnor ? ~(qm_next[i-1] ^ data[i]) : (qm_next[i-1] ^ data[i]);
    end
    qm_next[8] = ~use_xnor;
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      qm      <= '0;
      qm_ones <= '0;
      vde_d   <= 1'b0;
      c0_d    <= 1'b0;
      c1_d    <= 1'b0;
    end else begin
      qm      <= qm_next;
      qm_ones <= ones8(qm_next[7:0]);
      vde_d   <= vde;
      c0_d    <= c0;
      c1_d    <= c1;
    end
  end

  // diff = n1q - n0q = 2*n1q - 8, always in -8..+8
  assign diff = $signed({qm_ones, 1'b0} - 5'd8);

  always_comb begin
    sym_next = 10'h354;
    cnt_next = '0;
    if (!vde_d) begin
      case ({c1_d, c0_d})
        2'b00:   sym_next = 10'h354;
        2'b01:   sym_next = 10'h0AB;
        2'b10:   sym_next = 10'h154;
        2'b11:   sym_next = 10'h2AB;
        default: sym_next = 10'h354;
      endcase
    end else if ((cnt == 5'sd0) || (diff == 5'sd0)) begin
      sym_next = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_next = qm[8] ? (cnt + diff) : (cnt - diff);
    end else if (((cnt > 5'sd0) && (diff > 5'sd0)) || ((cnt < 5'sd0) && (diff < 5'sd0))) begin
      sym_next = {1'b1, qm[8], ~qm[7:0]};
      cnt_next = cnt + $signed({3'b000, qm[8], 1'b0}) - diff;
    end else begin
      sym_next = {1'b0, qm[8], qm[7:0]};
      cnt_next = cnt + diff - $signed({3'b000, ~qm[8], 1'b0});
    end
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      tmds <= 10'h354;
      cnt  <= '0;
    end else begin
      tmds <= sym_next;
      cnt  <= cnt_next;
    end
  end

endmodule

// File: tb/tb_tmds_encoder.sv
// Directed bench for tmds_encoder with a short reference-model soak at the end.
module tb_tmds_encoder;

  logic       pixclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       vde    = 1'b0;
  logic [7:0] data   = 8'h00;
  logic       c0     = 1'b0;
  logic       c1     = 1'b0;
  logic [9:0] tmds;

  int total = 0;
  int bad   = 0;
  int cnt_m = 0;

  logic [9:0] h_exp [2];
  logic       h_vld [2];
  string      h_tag [2];

  logic       r_v;
  logic [1:0] r_c;
  logic [7:0] r_d;

  always #5 pixclk = ~pixclk;

  tmds_encoder dut (
    .pixclk(pixclk),
    .rst_n (rst_n),
    .vde   (vde),
    .data  (data),
    .c0    (c0),
    .c1    (c1),
    .tmds  (tmds)
  );

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: tmds=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt();
    total++;
    assert (($signed(dut.cnt) >= -5'sd10) && ($signed(dut.cnt) <= 5'sd10)) else begin
      bad++;
      $error("FAIL cnt_bound: cnt=%0d expected within -10..10", $signed(dut.cnt));
    end
  endtask

  // Output observed at a negedge belongs to the input driven two negedges earlier.
  task automatic step(input logic v, input logic [1:0] c, input logic [7:0] d,
                      input logic chk, input logic [9:0] exp, input string tag);
    @(negedge pixclk);
    if (h_vld[1]) check(h_tag[1], tmds, h_exp[1]);
    h_exp[1] = h_exp[0];
    h_vld[1] = h_vld[0];
    h_tag[1] = h_tag[0];
    h_exp[0] = exp;
    h_vld[0] = chk;
    h_tag[0] = tag;
    vde  = v;
    {c1, c0} = c;
    data = d;
  endtask

  task automatic flush_to_reset(input string tag);
    h_exp[0] = 10'h354; h_vld[0] = 1'b1; h_tag[0] = tag;
    h_exp[1] = 10'h354; h_vld[1] = 1'b1; h_tag[1] = tag;
  endtask

  function automatic logic [9:0] model(input logic v, input logic [1:0] c, input logic [7:0] d);
    int         n1, n1q, n0q;
    logic       xn;
    logic [8:0] q;
    logic [9:0] s;
    if (!v) begin
      cnt_m = 0;
      case (c)
        2'd0:    s = 10'h354;
        2'd1:    s = 10'h0AB;
        2'd2:    s = 10'h154;
        default: s = 10'h2AB;
      endcase
      return s;
    end
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    q = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~xn;
    n1q = $countones(q[7:0]);
    n0q = 8 - n1q;
    if (cnt_m == 0 || n1q == n0q) begin
      s = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
      cnt_m = cnt_m + (q[8] ? (n1q - n0q) : (n0q - n1q));
    end else if ((cnt_m > 0 && n1q > n0q) || (cnt_m < 0 && n0q > n1q)) begin
      s = {1'b1, q[8], ~q[7:0]};
      cnt_m = cnt_m + (q[8] ? 2 : 0) + (n0q - n1q);
    end else begin
      s = {1'b0, q[8], q[7:0]};
      cnt_m = cnt_m + (n1q - n0q) - (q[8] ? 0 : 2);
    end
    return s;
  endfunction

  initial begin
    h_vld[0] = 1'b0;
    h_vld[1] = 1'b0;
    h_exp[0] = '0;
    h_exp[1] = '0;

    // held in reset with random inputs
    for (int i = 0; i < 4; i++) begin
      step(1'($urandom), 2'($urandom), 8'($urandom), 1'b1, 10'h354, "reset_hold");
      check("reset_now", tmds, 10'h354);
    end
    step(1'b0, 2'd0, 8'h00, 1'b1, 10'h354, "release0");
    rst_n = 1'b1;
    step(1'b0, 2'd0, 8'h00, 1'b1, 10'h354, "release1");

    // control symbols back to back
    step(1'b0, 2'd1, 8'h00, 1'b1, 10'h0AB, "ctl01");
    step(1'b0, 2'd2, 8'h00, 1'b1, 10'h154, "ctl10");
    step(1'b0, 2'd3, 8'h00, 1'b1, 10'h2AB, "ctl11");
    step(1'b0, 2'd0, 8'h00, 1'b1, 10'h354, "blank0");

    // disparity walk -8, 2, -6
    step(1'b1, 2'd0, 8'h00, 1'b1, 10'h100, "d00_a");
    step(1'b1, 2'd0, 8'h00, 1'b1, 10'h3FF, "d00_b");
    step(1'b1, 2'd0, 8'h00, 1'b1, 10'h100, "d00_c");
    step(1'b0, 2'd0, 8'h00, 1'b1, 10'h354, "blank1");

    step(1'b1, 2'd0, 8'hFF, 1'b1, 10'h200, "xnor_ff");
    step(1'b1, 2'd0, 8'hFF, 1'b1, 10'h0FF, "xnor_ff2");
    step(1'b0, 2'd0, 8'h00, 1'b1, 10'h354, "blank2");

    // blanking clears disparity
    step(1'b1, 2'd0, 8'h00, 1'b1, 10'h100, "clr_a");
    step(1'b0, 2'd0, 8'h00, 1'b1, 10'h354, "clr_blank");
    step(1'b1, 2'd0, 8'h00, 1'b1, 10'h100, "clr_b");

    step(1'b1, 2'd0, 8'h01, 1'b1, 10'h1FF, "d01_casec");
    step(1'b1, 2'd0, 8'h55, 1'b1, 10'h133, "d55_xor4");
    step(1'b1, 2'd0, 8'hAA, 1'b1, 10'h233, "daa_xnor4");
    step(1'b1, 2'd0, 8'hFE, 1'b1, 10'h2FF, "dfe_casea");
    step(1'b1, 2'd0, 8'hFF, 1'b1, 10'h200, "caseb_pos");
    step(1'b1, 2'd0, 8'h00, 1'b1, 10'h100, "d00_neg");
    step(1'b1, 2'd0, 8'hFE, 1'b1, 10'h2FF, "caseb_neg");
    step(1'b0, 2'd1, 8'h00, 1'b1, 10'h0AB, "ctl_after_data");
    step(1'b0, 2'd0, 8'h00, 1'b1, 10'h354, "blank3");

    // asynchronous reset in the middle of active video
    step(1'b1, 2'd0, 8'h3C, 1'b0, 10'h000, "pre_rst");
    step(1'b1, 2'd0, 8'h00, 1'b0, 10'h000, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", tmds, 10'h354);
    flush_to_reset("rst_flush");
    step(1'b1, 2'd0, 8'h00, 1'b1, 10'h354, "rst_mid");
    step(1'b0, 2'd0, 8'h00, 1'b1, 10'h354, "rst_rel");
    rst_n = 1'b1;
    step(1'b1, 2'd0, 8'hFF, 1'b1, 10'h200, "post_rst_ff");
    step(1'b0, 2'd0, 8'h00, 1'b1, 10'h354, "blank4");

    // random soak against the reference model, one reset injected
    cnt_m = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1700) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("soak_async_rst", tmds, 10'h354);
        flush_to_reset("soak_flush");
        step(1'($urandom), 2'($urandom), 8'($urandom), 1'b1, 10'h354, "soak_rst");
        step(1'b0, 2'd0, 8'h00, 1'b1, 10'h354, "soak_rel");
        rst_n = 1'b1;
        cnt_m = 0;
      end
      r_v = ($urandom_range(0, 7) != 0);
      r_c = 2'($urandom);
      r_d = 8'($urandom);
      step(r_v, r_c, r_d, 1'b1, model(r_v, r_c, r_d), "soak");
      check_cnt();
    end
    step(1'b0, 2'd0, 8'h00, 1'b0, 10'h000, "drain");
    step(1'b0, 2'd0, 8'h00, 1'b0, 10'h000, "drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
